demux4_widths_reg: RTL and testbench
====================================

Name: demux4_widths_reg

Overview:
- Registered 1:4 demultiplexer with valid/ready handshakes.
- Takes a single 8-bit input word plus a 2-bit select and routes the word to one of four output channels of width 4, 6, 7 and 8 bits.
- Narrow channels truncate the word; any non-zero dropped bits are flagged as overflow.
- Sits on the consumer side of the team's 4:1 zero-extending mux path and splits the shared 8-bit bus back into its native-width channels.

Parameters:
- COUNT_W, 8, width of the per-channel accepted-word counters; counters wrap modulo 2^COUNT_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  input word.
- in_sel  in  2  channel select: 00 → A, 01 → B, 10 → C, 11 → D.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word this cycle.
- a_data  out  4  channel A data (in_data[3:0]).
- a_valid  out  1  channel A holding register full.
- a_ready  in  1  channel A consumer ready.
- b_data  out  6  channel B data (in_data[5:0]).
- b_valid  out  1  channel B holding register full.
- b_ready  in  1  channel B consumer ready.
- c_data  out  7  channel C data (in_data[6:0]).
- c_valid  out  1  channel C holding register full.
- c_ready  in  1  channel C consumer ready.
- d_data  out  8  channel D data (in_data[7:0]).
- d_valid  out  1  channel D holding register full.
- d_ready  in  1  channel D consumer ready.
- ovf  out  4  sticky overflow flags, bit0 = A … bit3 = D.
- ovf_clr  in  1  clears all ovf bits.
- cnt_a, cnt_b, cnt_c, cnt_d  out  COUNT_W each  accepted-word counters, one per channel.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - all *_valid ← 0, all *_data ← 0, ovf ← 0, all cnt_* ← 0.
  - rst overrides every other input that cycle.
  - in_ready is combinational, so it may be high during reset; any handshake in that cycle is discarded.
- in_ready (combinational):
  - in_ready = !ch_valid[in_sel] | ch_ready[in_sel].
  - Depends only on in_sel and the selected channel's state, never on in_valid.
  - Non-selected channels never stall the input.
- Accept: in_valid & in_ready on a clock edge.
  - Selected channel's data register ← truncated word; its valid ← 1; its cnt ← cnt + 1 (wraps 2^COUNT_W−1 → 0).
  - Latency: the word appears on the channel outputs in the cycle after acceptance.
- Drain: ch_valid & ch_ready with no simultaneous reload → valid ← 0.
  - Data register holds its last value after draining (not cleared).
- Simultaneous drain and reload on the same channel:
  - valid stays 1; data updates to the new word.
  - Full throughput of 1 word/cycle per channel is sustained while the consumer holds ready high.
- Back-pressure: while ch_valid & !ch_ready, data and valid are held stable (AXI-stream-style rule).
- Truncation and overflow, per channel:
  - A: overflow if in_data[7:4] ≠ 0.
  - B: overflow if in_data[7:6] ≠ 0.
  - C: overflow if in_data[7] ≠ 0.
  - D: never overflows.
  - Overflow is evaluated only on an accepted word.
  - The truncated word is still delivered, and the corresponding ovf bit is set.
- ovf_clr:
  - Clears all ovf bits at the next edge.
  - If ovf_clr and a new overflow occur in the same cycle, set wins: that bit = 1, other bits cleared.
- in_valid = 0: no state change except drains.
- in_sel may change freely while in_valid = 0. While in_valid & !in_ready, the producer holds in_data and in_sel stable.

Decomposition:
- Package demux4_pkg holds:
  - localparams W_A = 4, W_B = 6, W_C = 7, W_D = 8, W_BUS = 8.
  - select encodings SEL_A = 2'b00, SEL_B = 2'b01, SEL_C = 2'b10, SEL_D = 2'b11.
- Sub-module demux_chan_reg (parameters W, COUNT_W), instantiated 4×:
  - contains the holding register, valid flag, ready logic, counter and sticky overflow bit.
  - inputs: load, word, ovf_in, ovf_clr.
- The top level handles select decode, the in_ready mux and the overflow comparators.

Test Plan:
- Reset: rst = 1 for 2 cycles with in_valid = 1 → all *_valid = 0, ovf = 0, cnt_* = 0; no counter increments after rst falls unless a new handshake occurs.
- Routing: sel = 00, data 0x0A → next cycle a_data = 4'hA, a_valid = 1, ovf = 0, cnt_a = 1. Repeat with sel = 01/0x2C, sel = 10/0x55 and sel = 11/0xFF → b_data = 6'h2C, c_data = 7'h55, d_data = 8'hFF, ovf = 0.
- Overflow and clear:
  - sel = 00, data 0x3A → a_data = 4'hA, ovf = 4'b0001.
  - sel = 10, data 0x80 → c_data = 0, ovf = 4'b0101.
  - Assert ovf_clr alone → ovf = 0.
  - Assert ovf_clr together with sel = 01, data 0xC1 → ovf = 4'b0010.
- Back-pressure:
  - a_ready = 0, accept 0x01 on A → in_ready = 0 while sel = 00, but sel = 11 is still accepted.
  - a_data holds 4'h1 for 5 cycles.
  - Raise a_ready → drain in that cycle; the next A word is accepted the same cycle.
- Throughput and wrap:
  - a_ready = 1, 256 back-to-back words on A → one word delivered per cycle, in order.
  - cnt_a wraps to 0 (COUNT_W = 8); a_valid stays high throughout.
- Mid-operation reset: with all four channels full and stalled, pulse rst for 1 cycle → all *_valid = 0 and cnt_* = 0 next cycle; the next accepted word behaves as the first after reset.

Source files
------------

// File: rtl/demux4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_pkg
//  Description : Shared widths and select encodings for the registered 1:4
//                demultiplexer that splits the 8-bit bus into native channels.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux4_pkg;

    // Native channel widths and the shared bus width
    localparam int W_A   = 4;
    localparam int W_B   = 6;
    localparam int W_C   = 7;
    localparam int W_D   = 8;
    localparam int W_BUS = 8;

    // Channel select encodings
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage : demux4_pkg
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_chan_reg
//  Description : One output channel: single-entry holding register with valid
//                flag, load-permission logic, wrapping accepted-word counter
//                and sticky overflow bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_reg #(
    parameter int W       = 8,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,      // accepted word targets this channel
    input  logic [W-1:0]       word,      // already-truncated word
    input  logic               ovf_in,    // accepted word lost non-zero bits
    input  logic               ovf_clr,
    input  logic               ready,     // consumer ready
    output logic [W-1:0]       data,
    output logic               valid,
    output logic               can_load,  // register is empty or draining now
    output logic [COUNT_W-1:0] cnt,
    output logic               ovf
);

    logic [W-1:0]       r_data;
    logic               r_valid;
    logic [COUNT_W-1:0] r_cnt;
    logic               r_ovf;

    // A full register may still take a word in the same cycle it drains
    assign can_load = ~r_valid | ready;

    // Holding register, valid flag and counter; data is kept after draining
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (load) begin
            r_data  <= word;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + COUNT_W'(1);
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overflow: a new overflow wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (ovf_in) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign cnt   = r_cnt;
    assign ovf   = r_ovf;

endmodule : demux_chan_reg
`default_nettype wire

// File: rtl/demux4_widths_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_widths_reg
//  Description : Registered 1:4 demultiplexer with valid/ready handshakes.
//                Routes an 8-bit word to 4/6/7/8-bit channels, truncating
//                and flagging any lost non-zero bits as sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux4_widths_reg
    import demux4_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_BUS-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W_A-1:0]     a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [W_B-1:0]     b_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [W_C-1:0]     c_data,
    output logic               c_valid,
    input  logic               c_ready,
    output logic [W_D-1:0]     d_data,
    output logic               d_valid,
    input  logic               d_ready,
    output logic [3:0]         ovf,
    input  logic               ovf_clr,
    output logic [COUNT_W-1:0] cnt_a,
    output logic [COUNT_W-1:0] cnt_b,
    output logic [COUNT_W-1:0] cnt_c,
    output logic [COUNT_W-1:0] cnt_d
);

    logic [3:0] w_can_load;
    logic [3:0] w_load;
    logic [3:0] w_ovf_in;
    logic       w_accept;

    // Only the selected channel can stall the producer
    assign in_ready = w_can_load[in_sel];
    assign w_accept = in_valid & in_ready;

    // One-hot load strobe for the channel addressed by the accepted word
    always_comb begin
        w_load = 4'b0000;
        if (w_accept) begin
            w_load[in_sel] = 1'b1;
        end
    end

    // Overflow only counts for a word actually accepted into that channel
    assign w_ovf_in[SEL_A] = w_load[SEL_A] & (in_data[W_BUS-1:W_A] != '0);
    assign w_ovf_in[SEL_B] = w_load[SEL_B] & (in_data[W_BUS-1:W_B] != '0);
    assign w_ovf_in[SEL_C] = w_load[SEL_C] & (in_data[W_BUS-1:W_C] != '0);
    assign w_ovf_in[SEL_D] = 1'b0;

    demux_chan_reg #(.W(W_A), .COUNT_W(COUNT_W)) u_chan_a (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load[SEL_A]),
        .word     (in_data[W_A-1:0]),
        .ovf_in   (w_ovf_in[SEL_A]),
        .ovf_clr  (ovf_clr),
        .ready    (a_ready),
        .data     (a_data),
        .valid    (a_valid),
        .can_load (w_can_load[SEL_A]),
        .cnt      (cnt_a),
        .ovf      (ovf[SEL_A])
    );

    demux_chan_reg #(.W(W_B), .COUNT_W(COUNT_W)) u_chan_b (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load[SEL_B]),
        .word     (in_data[W_B-1:0]),
        .ovf_in   (w_ovf_in[SEL_B]),
        .ovf_clr  (ovf_clr),
        .ready    (b_ready),
        .data     (b_data),
        .valid    (b_valid),
        .can_load (w_can_load[SEL_B]),
        .cnt      (cnt_b),
        .ovf      (ovf[SEL_B])
    );

    demux_chan_reg #(.W(W_C), .COUNT_W(COUNT_W)) u_chan_c (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load[SEL_C]),
        .word     (in_data[W_C-1:0]),
        .ovf_in   (w_ovf_in[SEL_C]),
        .ovf_clr  (ovf_clr),
        .ready    (c_ready),
        .data     (c_data),
        .valid    (c_valid),
        .can_load (w_can_load[SEL_C]),
        .cnt      (cnt_c),
        .ovf      (ovf[SEL_C])
    );

    demux_chan_reg #(.W(W_D), .COUNT_W(COUNT_W)) u_chan_d (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load[SEL_D]),
        .word     (in_data[W_D-1:0]),
        .ovf_in   (w_ovf_in[SEL_D]),
        .ovf_clr  (ovf_clr),
        .ready    (d_ready),
        .data     (d_data),
        .valid    (d_valid),
        .can_load (w_can_load[SEL_D]),
        .cnt      (cnt_d),
        .ovf      (ovf[SEL_D])
    );

endmodule : demux4_widths_reg
`default_nettype wire

// File: tb/tb_demux4_widths_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux4_widths_reg
//  Description : Self-checking bench for demux4_widths_reg: directed cases
//                with literal expectations, then randomized traffic compared
//                every cycle against a behavioural channel model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_widths_reg;

    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [3:0]         a_data;
    logic               a_valid;
    logic               a_ready = 1'b1;
    logic [5:0]         b_data;
    logic               b_valid;
    logic               b_ready = 1'b1;
    logic [6:0]         c_data;
    logic               c_valid;
    logic               c_ready = 1'b1;
    logic [7:0]         d_data;
    logic               d_valid;
    logic               d_ready = 1'b1;
    logic [3:0]         ovf;
    logic               ovf_clr = 1'b0;
    logic [COUNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

    demux4_widths_reg #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
        .ovf(ovf), .ovf_clr(ovf_clr),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: each channel is a one-word slot holding the word
    // modulo 2^width; overflow means the word was >= 2^width.
    // ------------------------------------------------------------------
    int         wid[4] = '{4, 6, 7, 8};
    int         mdat[4];
    bit         mval[4];
    int         mcnt[4];
    bit   [3:0] movf;
    bit         m_init = 1'b0;
    bit         m_stalled = 1'b0;

    always @(posedge clk) begin
        bit [3:0] rdy;
        bit [3:0] nov;
        int       s;
        int       w;
        bit       acc;
        rdy = {d_ready, c_ready, b_ready, a_ready};
        s   = int'(in_sel);
        w   = int'(in_data);
        if (rst) begin
            m_init <= 1'b1;
            m_stalled <= 1'b0;
            movf <= '0;
            for (int i = 0; i < 4; i++) begin
                mdat[i] <= 0;
                mval[i] <= 1'b0;
                mcnt[i] <= 0;
            end
        end else begin
            acc = in_valid && (!mval[s] || rdy[s]);
            m_stalled <= in_valid && !acc;
            for (int i = 0; i < 4; i++)
                if (mval[i] && rdy[i]) mval[i] <= 1'b0;
            nov = ovf_clr ? 4'b0000 : movf;
            if (acc) begin
                mval[s] <= 1'b1;
                mdat[s] <= w % (1 << wid[s]);
                mcnt[s] <= (mcnt[s] + 1) % (1 << COUNT_W);
                if (w >= (1 << wid[s])) nov[s] = 1'b1;
            end
            movf <= nov;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        bit [3:0] rdy;
        rdy = {d_ready, c_ready, b_ready, a_ready};
        if (m_init) begin
            chk("m_a_data",  int'(a_data),  mdat[0]);
            chk("m_b_data",  int'(b_data),  mdat[1]);
            chk("m_c_data",  int'(c_data),  mdat[2]);
            chk("m_d_data",  int'(d_data),  mdat[3]);
            chk("m_a_valid", int'(a_valid), int'(mval[0]));
            chk("m_b_valid", int'(b_valid), int'(mval[1]));
            chk("m_c_valid", int'(c_valid), int'(mval[2]));
            chk("m_d_valid", int'(d_valid), int'(mval[3]));
            chk("m_cnt_a",   int'(cnt_a),   mcnt[0]);
            chk("m_cnt_b",   int'(cnt_b),   mcnt[1]);
            chk("m_cnt_c",   int'(cnt_c),   mcnt[2]);
            chk("m_cnt_d",   int'(cnt_d),   mcnt[3]);
            chk("m_ovf",     int'(ovf),     int'(movf));
            chk("m_in_ready", int'(in_ready),
                int'(!mval[int'(in_sel)] || rdy[int'(in_sel)]));
        end
    end

    // Inputs change 1 time unit after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        in_sel   = s;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with a word offered
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'b00; in_data = 8'h0F;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("rst_valids", int'({d_valid, c_valid, b_valid, a_valid}), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_cnts", int'(cnt_a) + int'(cnt_b) + int'(cnt_c) + int'(cnt_d), 0);

        // Routing
        send(2'b00, 8'h0A);
        chk("rt_a_data", int'(a_data), 'hA);
        chk("rt_a_valid", int'(a_valid), 1);
        chk("rt_ovf0", int'(ovf), 0);
        chk("rt_cnt_a", int'(cnt_a), 1);
        send(2'b01, 8'h2C);
        chk("rt_b_data", int'(b_data), 'h2C);
        chk("rt_a_drained", int'(a_valid), 0);
        chk("rt_a_held", int'(a_data), 'hA);
        send(2'b10, 8'h55);
        chk("rt_c_data", int'(c_data), 'h55);
        send(2'b11, 8'hFF);
        chk("rt_d_data", int'(d_data), 'hFF);
        chk("rt_ovf1", int'(ovf), 0);

        // Overflow and clear
        send(2'b00, 8'h3A);
        chk("ov_a_data", int'(a_data), 'hA);
        chk("ov_a", int'(ovf), 'b0001);
        send(2'b10, 8'h80);
        chk("ov_c_data", int'(c_data), 0);
        chk("ov_ac", int'(ovf), 'b0101);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ov_clr", int'(ovf), 0);
        ovf_clr = 1'b1; send(2'b01, 8'hC1); ovf_clr = 1'b0;
        chk("ov_clr_set", int'(ovf), 'b0010);
        chk("ov_b_data", int'(b_data), 'h01);

        // Back-pressure on A
        a_ready = 1'b0;
        send(2'b00, 8'h01);
        chk("bp_a_data", int'(a_data), 1);
        in_sel = 2'b11; in_data = 8'h33; in_valid = 1'b1; #1;
        chk("bp_d_ready", int'(in_ready), 1);
        tick(); in_valid = 1'b0;
        chk("bp_d_data", int'(d_data), 'h33);
        in_sel = 2'b00; in_data = 8'h02; in_valid = 1'b1; #1;
        chk("bp_a_stall", int'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_a_hold", int'(a_data), 1);
            chk("bp_a_vhold", int'(a_valid), 1);
        end
        a_ready = 1'b1; #1;
        chk("bp_a_rdy", int'(in_ready), 1);
        tick(); in_valid = 1'b0;
        chk("bp_a_new", int'(a_data), 2);
        chk("bp_a_v", int'(a_valid), 1);
        chk("bp_cnt_a", int'(cnt_a), 4);

        // Throughput and counter wrap
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_sel = 2'b00; in_data = 8'(i); in_valid = 1'b1;
            tick();
            chk("tp_a_data", int'(a_data), i % 16);
            chk("tp_a_valid", int'(a_valid), 1);
            if (i == 254) chk("tp_cnt_255", int'(cnt_a), 255);
        end
        in_valid = 1'b0;
        chk("tp_cnt_wrap", int'(cnt_a), 0);
        tick();

        // Mid-operation reset with all channels full and stalled
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0; d_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'(i), 8'(8'h10 + i));
        chk("mr_full", int'({d_valid, c_valid, b_valid, a_valid}), 'hF);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mr_valids", int'({d_valid, c_valid, b_valid, a_valid}), 0);
        chk("mr_cnts", int'(cnt_a) + int'(cnt_b) + int'(cnt_c) + int'(cnt_d), 0);
        a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
        send(2'b01, 8'h05);
        chk("mr_cnt_b", int'(cnt_b), 1);
        chk("mr_b_data", int'(b_data), 5);
        chk("mr_ovf", int'(ovf), 0);

        // Randomized traffic; producer holds its word while stalled
        for (int n = 0; n < 3000; n++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            c_ready = ($urandom_range(0, 1) != 0);
            d_ready = ($urandom_range(0, 4) != 0);
            rst     = ($urandom_range(0, 199) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
            if (!m_stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) != 0)
                    in_data = 8'($urandom_range(0, 15));
                else
                    in_data = 8'($urandom);
            end
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_demux4_widths_reg
`default_nettype wire
